ew_mul_scheduler: RTL and testbench
===================================

Name: ew_mul_scheduler

Overview:
- Sequences one element-wise quantized multiply op over the int8 MUL datapath.
- On `start` it latches the op descriptor and drives stable requant parameters to the datapath.
- Streams read addresses for both operand buffers and asserts the datapath's `input_valid` one cycle after each read.
- Counts returning results, issues output-buffer writes, and pulses `done` when every element has been written back.

Parameters:
- ADDR_W, 16, element address and count width.
- MUL_LAT, 4, cycles from `dp_in_valid` to `dp_out_valid` in the MUL datapath (used only for assertions and drain checks).
- INT32_SIZE, 32, quantization parameter width (from params.vh).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle op request; ignored unless idle
- elem_count  in  ADDR_W  number of elements; 0 is legal
- in1_base, in2_base, out_base  in  ADDR_W each  buffer base addresses
- in2_broadcast  in  1  in2 is a scalar: `rd_addr2` stays at `in2_base`
- p_in1_off, p_in2_off, p_mult, p_shift, p_out_off, p_act_min, p_act_max  in  INT32_SIZE each  requant parameters
- issue_hold  in  1  stall new reads; in-flight elements still complete
- rd_en  out  1  operand buffer read strobe
- rd_addr1, rd_addr2  out  ADDR_W  operand addresses
- dp_in_valid  out  1  to the MUL datapath's `input_valid`
- cfg_in1_off … cfg_act_max  out  INT32_SIZE each  latched parameters to the datapath
- dp_out_valid  in  1  from the MUL datapath's `valid`
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  output address
- busy  out  1  op in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is `rst`, asynchronous, active-low; clock is `clk`.
- Reset values: all outputs 0, FSM to IDLE, counters 0, cfg registers 0. Reset mid-op abandons the op; no `done`.
- FSM: IDLE -> CFG -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - `start`=1 latches the descriptor and all `p_*` into cfg registers, then goes to CFG.
  - If `elem_count`==0, goes directly to DONE instead.
- CFG (1 cycle): gives the datapath's registered parameters one settle cycle before the first valid. `busy`=1 from CFG through DONE inclusive.
- RUN, each cycle with `issue_hold`=0 and issued<count:
  - `rd_en`=1, `rd_addr1` = in1_base+issued.
  - `rd_addr2` = in2_broadcast ? in2_base : in2_base+issued.
  - issued increments.
  - When issued reaches count after this issue, go to DRAIN.
  - `issue_hold`=1 gives `rd_en`=0 with no counter change.
- `dp_in_valid` is `rd_en` delayed by exactly 1 cycle (buffer read latency 1). Throughput is 1 element/cycle.
- Write-back, in RUN and DRAIN:
  - `wr_en` = `dp_out_valid` combinationally.
  - `wr_addr` = out_base+completed; completed increments on each `dp_out_valid`.
  - `dp_out_valid` while IDLE/CFG/DONE is ignored: no write, no count.
- DRAIN: when completed reaches count (including on the cycle of the final write), go to DONE.
- DONE: `done`=1 for 1 cycle, `busy`=1, then IDLE. The next `start` is accepted one cycle after `done`.
- Arithmetic:
  - Address adds are unsigned, modulo 2^ADDR_W; wrap-around past the buffer end is allowed and not flagged.
  - Counters are ADDR_W wide; an `elem_count` of 2^ADDR_W-1 works.
- Simultaneous events:
  - An issue and a write in the same cycle both proceed.
  - `start` while `busy` is dropped.
  - cfg outputs stay constant from CFG until the next accepted start.
- Invariants:
  - completed ≤ issued ≤ count.
  - Each write occurs MUL_LAT+1 cycles after its `rd_en`.

Decomposition:
- Shared params.vh holds INT8_SIZE, INT32_SIZE, the FSM state encodings (IDLE=0, CFG=1, RUN=2, DRAIN=3, DONE=4) and the default MUL_LAT.
- One natural sub-module, `ew_addr_gen`: base+counter address generation with the broadcast select, instanced for the read side and the write side.
- The FSM, cfg registers and `rd_en` delay stay in the top module.

Test Plan:
- Basic op: count=8, bases 0x10/0x20/0x30, no hold, MUL model latency 4.
  - `rd_en` is high for 8 consecutive cycles starting 2 cycles after `start`, addresses 0x10..0x17 and 0x20..0x27.
  - Writes go to 0x30..0x37, each 5 cycles after its read; `done` pulses once, the cycle after the last write.
- Broadcast: count=5, `in2_broadcast`=1, in2_base=0x40 -> `rd_addr2` is 0x40 on all 5 reads; `rd_addr1` increments normally.
- Hold: count=6, `issue_hold` high for 3 cycles after the 2nd issue.
  - Exactly 6 reads with a 3-cycle gap; 6 writes to contiguous addresses; `done` after the 6th write.
  - cfg outputs stay stable throughout.
- Zero count and busy start:
  - count=0 -> `busy` high 1 cycle, `done` pulses 1 cycle after `start`, no `rd_en` or `wr_en`.
  - A second `start` during a count=10 op -> ignored; descriptor and cfg unchanged.
- Wrap: in1_base=0xFFFE, count=4 -> `rd_addr1` is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-op: assert `rst` low during RUN of a count=20 op.
  - All outputs go 0 immediately; no `done`.
  - Stray `dp_out_valid` pulses after reset produce no `wr_en`; a new op then completes normally.

Source files
------------

// File: rtl/ew_mul_scheduler_pkg.sv
// Shared types and constants for the element-wise MUL scheduler.
// Holds datapath widths, the default MUL latency and the FSM encoding.
package ew_mul_scheduler_pkg;

  localparam int INT8_SIZE   = 8;
  localparam int INT32_SIZE  = 32;
  localparam int MUL_LAT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ew_mul_scheduler_addr_gen.sv
// Address generator: base + index, or base alone when broadcasting.
// Ports: base, idx, bcast in; addr out. Adds wrap modulo 2^ADDR_W.
module ew_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] idx,
  input  logic              bcast,
  output logic [ADDR_W-1:0] addr
);

  assign addr = bcast ? base : base + idx;

endmodule

// File: rtl/ew_mul_scheduler.sv
// Sequences one element-wise quantized multiply over the int8 MUL datapath.
// Ports: start/descriptor/p_* in, rd_*/dp_in_valid/cfg_*/wr_*/busy/done out.
module ew_mul_scheduler
  import ew_mul_scheduler_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MUL_LAT    = ew_mul_scheduler_pkg::MUL_LAT_DEF,
  parameter int INT32_SIZE = ew_mul_scheduler_pkg::INT32_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     elem_count,
  input  logic [ADDR_W-1:0]     in1_base,
  input  logic [ADDR_W-1:0]     in2_base,
  input  logic [ADDR_W-1:0]     out_base,
  input  logic                  in2_broadcast,
  input  logic [INT32_SIZE-1:0] p_in1_off,
  input  logic [INT32_SIZE-1:0] p_in2_off,
  input  logic [INT32_SIZE-1:0] p_mult,
  input  logic [INT32_SIZE-1:0] p_shift,
  input  logic [INT32_SIZE-1:0] p_out_off,
  input  logic [INT32_SIZE-1:0] p_act_min,
  input  logic [INT32_SIZE-1:0] p_act_max,
  input  logic                  issue_hold,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr1,
  output logic [ADDR_W-1:0]     rd_addr2,
  output logic                  dp_in_valid,
  output logic [INT32_SIZE-1:0] cfg_in1_off,
  output logic [INT32_SIZE-1:0] cfg_in2_off,
  output logic [INT32_SIZE-1:0] cfg_mult,
  output logic [INT32_SIZE-1:0] cfg_shift,
  output logic [INT32_SIZE-1:0] cfg_out_off,
  output logic [INT32_SIZE-1:0] cfg_act_min,
  output logic [INT32_SIZE-1:0] cfg_act_max,
  input  logic                  dp_out_valid,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [7:0]        LAT8 = 8'(MUL_LAT);

  state_t state, state_d;

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] completed;
  logic [ADDR_W-1:0] b1_q;
  logic [ADDR_W-1:0] b2_q;
  logic [ADDR_W-1:0] bo_q;
  logic              bcast_q;
  logic [7:0]        drain_cyc;
  logic [ADDR_W-1:0] issued_nx;
  logic [ADDR_W-1:0] completed_nx;
  logic              accept;

  assign issued_nx    = issued + ONE;
  assign completed_nx = completed + ONE;
  assign accept       = (state == S_IDLE) && start;

  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = (elem_count == '0) ? S_DONE : S_CFG;
        end
      end
      S_CFG: begin
        busy    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        wr_en = dp_out_valid && (completed != count_q);
        rd_en = !issue_hold && (issued != count_q);
        if (rd_en && (issued_nx == count_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy  = 1'b1;
        wr_en = dp_out_valid && (completed != count_q);
        // Leave on the very cycle the last result is written.
        if ((completed == count_q) ||
            (wr_en && (completed_nx == count_q))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      dp_in_valid <= 1'b0;
      count_q     <= '0;
      issued      <= '0;
      completed   <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      bo_q        <= '0;
      bcast_q     <= 1'b0;
      drain_cyc   <= '0;
      cfg_in1_off <= '0;
      cfg_in2_off <= '0;
      cfg_mult    <= '0;
      cfg_shift   <= '0;
      cfg_out_off <= '0;
      cfg_act_min <= '0;
      cfg_act_max <= '0;
    end else begin
      state       <= state_d;
      // Operand buffers have one cycle of read latency.
      dp_in_valid <= rd_en;
      drain_cyc   <= (state == S_DRAIN) ? drain_cyc + 8'd1 : 8'd0;
      if (accept) begin
        count_q     <= elem_count;
        issued      <= '0;
        completed   <= '0;
        b1_q        <= in1_base;
        b2_q        <= in2_base;
        bo_q        <= out_base;
        bcast_q     <= in2_broadcast;
        cfg_in1_off <= p_in1_off;
        cfg_in2_off <= p_in2_off;
        cfg_mult    <= p_mult;
        cfg_shift   <= p_shift;
        cfg_out_off <= p_out_off;
        cfg_act_min <= p_act_min;
        cfg_act_max <= p_act_max;
      end else begin
        if (rd_en) issued <= issued_nx;
        if (wr_en) completed <= completed_nx;
      end
    end
  end

  ew_addr_gen #(.ADDR_W(ADDR_W)) u_rd1 (
    .base  (b1_q),
    .idx   (issued),
    .bcast (1'b0),
    .addr  (rd_addr1)
  );

  ew_addr_gen #(.ADDR_W(ADDR_W)) u_rd2 (
    .base  (b2_q),
    .idx   (issued),
    .bcast (bcast_q),
    .addr  (rd_addr2)
  );

  ew_addr_gen #(.ADDR_W(ADDR_W)) u_wr (
    .base  (bo_q),
    .idx   (completed),
    .bcast (1'b0),
    .addr  (wr_addr)
  );

  // The last result lands MUL_LAT cycles into DRAIN at the latest.
  a_drain_bound: assert property (@(posedge clk) disable iff (!rst)
    !((state == S_DRAIN) && (drain_cyc > LAT8)));

  a_count_order: assert property (@(posedge clk) disable iff (!rst)
    (completed <= issued) && (issued <= count_q));

endmodule

// File: tb/tb_ew_mul_scheduler.sv
// Directed self-checking bench for ew_mul_scheduler.
// Models the MUL datapath as a 4-deep valid pipe and logs strobes per cycle.
module tb_ew_mul_scheduler;

  localparam int AW  = 16;
  localparam int IW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] elem_count = '0;
  logic [AW-1:0] in1_base = '0;
  logic [AW-1:0] in2_base = '0;
  logic [AW-1:0] out_base = '0;
  logic          in2_broadcast = 1'b0;
  logic [IW-1:0] p_in1_off = '0;
  logic [IW-1:0] p_in2_off = '0;
  logic [IW-1:0] p_mult = '0;
  logic [IW-1:0] p_shift = '0;
  logic [IW-1:0] p_out_off = '0;
  logic [IW-1:0] p_act_min = '0;
  logic [IW-1:0] p_act_max = '0;
  logic          issue_hold = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          dp_in_valid;
  logic [IW-1:0] cfg_in1_off;
  logic [IW-1:0] cfg_in2_off;
  logic [IW-1:0] cfg_mult;
  logic [IW-1:0] cfg_shift;
  logic [IW-1:0] cfg_out_off;
  logic [IW-1:0] cfg_act_min;
  logic [IW-1:0] cfg_act_max;
  logic          dp_out_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  ew_mul_scheduler #(.ADDR_W(AW), .MUL_LAT(LAT), .INT32_SIZE(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .elem_count    (elem_count),
    .in1_base      (in1_base),
    .in2_base      (in2_base),
    .out_base      (out_base),
    .in2_broadcast (in2_broadcast),
    .p_in1_off     (p_in1_off),
    .p_in2_off     (p_in2_off),
    .p_mult        (p_mult),
    .p_shift       (p_shift),
    .p_out_off     (p_out_off),
    .p_act_min     (p_act_min),
    .p_act_max     (p_act_max),
    .issue_hold    (issue_hold),
    .rd_en         (rd_en),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .dp_in_valid   (dp_in_valid),
    .cfg_in1_off   (cfg_in1_off),
    .cfg_in2_off   (cfg_in2_off),
    .cfg_mult      (cfg_mult),
    .cfg_shift     (cfg_shift),
    .cfg_out_off   (cfg_out_off),
    .cfg_act_min   (cfg_act_min),
    .cfg_act_max   (cfg_act_max),
    .dp_out_valid  (dp_out_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: result valid LAT cycles after its input valid.
  logic [LAT-1:0] pipe = '0;
  logic           stray = 1'b0;
  always @(posedge clk) pipe <= {pipe[LAT-2:0], dp_in_valid};
  assign dp_out_valid = pipe[LAT-1] | stray;

  int            rd_c[$];
  logic [AW-1:0] rd_a1[$];
  logic [AW-1:0] rd_a2[$];
  int            wr_c[$];
  logic [AW-1:0] wr_a[$];
  int            dn_c[$];
  int            busy_n = 0;
  int            cfg_chg = 0;
  logic          prev_busy = 1'b0;
  logic [7*IW-1:0] prev_cfg = '0;
  logic [7*IW-1:0] cur_cfg;

  assign cur_cfg = {cfg_in1_off, cfg_in2_off, cfg_mult, cfg_shift,
                    cfg_out_off, cfg_act_min, cfg_act_max};

  always @(negedge clk) begin
    if (rd_en) begin
      rd_c.push_back(cyc);
      rd_a1.push_back(rd_addr1);
      rd_a2.push_back(rd_addr2);
    end
    if (wr_en) begin
      wr_c.push_back(cyc);
      wr_a.push_back(wr_addr);
    end
    if (done) dn_c.push_back(cyc);
    if (busy) busy_n++;
    if (busy && prev_busy && (cur_cfg !== prev_cfg)) cfg_chg++;
    prev_busy = busy;
    prev_cfg  = cur_cfg;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    rd_c.delete();
    rd_a1.delete();
    rd_a2.delete();
    wr_c.delete();
    wr_a.delete();
    dn_c.delete();
    busy_n  = 0;
    cfg_chg = 0;
  endtask

  task automatic set_p(input logic [IW-1:0] seed);
    p_in1_off = seed + 32'd1;
    p_in2_off = seed + 32'd2;
    p_mult    = seed + 32'd3;
    p_shift   = seed + 32'd4;
    p_out_off = seed + 32'd5;
    p_act_min = seed + 32'd6;
    p_act_max = seed + 32'd7;
  endtask

  task automatic op(input logic [AW-1:0] cnt, input logic [AW-1:0] b1,
                    input logic [AW-1:0] b2, input logic [AW-1:0] bo,
                    input logic bc, input logic [IW-1:0] seed,
                    output int s);
    @(posedge clk);
    #1;
    elem_count    = cnt;
    in1_base      = b1;
    in2_base      = b2;
    out_base      = bo;
    in2_broadcast = bc;
    set_p(seed);
    start         = 1'b1;
    s             = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reads start 2 cycles after start; reads with index >= g_at slip by g_len.
  task automatic check_op(input string tag, input int n,
                          input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                          input logic [AW-1:0] bo, input logic bc,
                          input int s, input int g_at, input int g_len,
                          input logic [IW-1:0] seed);
    int re;
    int last;
    logic [AW-1:0] e1, e2, eo;
    last = 0;
    chk({tag, ".rd_n"}, rd_c.size(), n);
    chk({tag, ".wr_n"}, wr_c.size(), n);
    for (int i = 0; i < n; i++) begin
      re = s + 2 + i + ((i >= g_at) ? g_len : 0);
      e1 = b1 + AW'(i);
      e2 = bc ? b2 : b2 + AW'(i);
      eo = bo + AW'(i);
      chk({tag, ".rd_cyc"}, (i < rd_c.size()) ? rd_c[i] : -1, re);
      chk({tag, ".rd_a1"}, (i < rd_a1.size()) ? rd_a1[i] : 'x, e1);
      chk({tag, ".rd_a2"}, (i < rd_a2.size()) ? rd_a2[i] : 'x, e2);
      chk({tag, ".wr_cyc"}, (i < wr_c.size()) ? wr_c[i] : -1, re + 5);
      chk({tag, ".wr_a"}, (i < wr_a.size()) ? wr_a[i] : 'x, eo);
      last = re;
    end
    chk({tag, ".done_n"}, dn_c.size(), 1);
    chk({tag, ".done_cyc"}, (dn_c.size() > 0) ? dn_c[0] : -1, last + 6);
    chk({tag, ".cfg_mult"}, cfg_mult, seed + 32'd3);
    chk({tag, ".cfg_act_max"}, cfg_act_max, seed + 32'd7);
    chk({tag, ".cfg_chg"}, cfg_chg, 0);
  endtask

  initial begin
    int s;

    #2;
    chk("rst.rd_en", rd_en, 0);
    chk("rst.dp_in_valid", dp_in_valid, 0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cfg_mult", cfg_mult, 0);
    chk("rst.rd_addr1", rd_addr1, 0);
    chk("rst.wr_addr", wr_addr, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    clear_log();
    op(16'd8, 16'h0010, 16'h0020, 16'h0030, 1'b0, 32'h0100_0000, s);
    tick(20);
    check_op("basic", 8, 16'h0010, 16'h0020, 16'h0030, 1'b0, s, 99, 0,
             32'h0100_0000);

    clear_log();
    op(16'd5, 16'h0050, 16'h0040, 16'h0060, 1'b1, 32'h0200_0000, s);
    tick(20);
    check_op("bcast", 5, 16'h0050, 16'h0040, 16'h0060, 1'b1, s, 99, 0,
             32'h0200_0000);

    clear_log();
    op(16'd6, 16'h0080, 16'h0090, 16'h00A0, 1'b0, 32'h0300_0000, s);
    set_p(32'hDEAD_0000);
    tick(3);
    issue_hold = 1'b1;
    tick(3);
    issue_hold = 1'b0;
    tick(20);
    check_op("hold", 6, 16'h0080, 16'h0090, 16'h00A0, 1'b0, s, 2, 3,
             32'h0300_0000);

    clear_log();
    op(16'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 32'h0400_0000, s);
    tick(5);
    chk("zero.done_n", dn_c.size(), 1);
    chk("zero.done_cyc", (dn_c.size() > 0) ? dn_c[0] : -1, s + 1);
    chk("zero.busy_n", busy_n, 1);
    chk("zero.rd_n", rd_c.size(), 0);
    chk("zero.wr_n", wr_c.size(), 0);

    clear_log();
    op(16'd10, 16'h0100, 16'h0200, 16'h0300, 1'b0, 32'h0500_0000, s);
    tick(3);
    elem_count    = 16'd3;
    in1_base      = 16'h0A00;
    in2_base      = 16'h0B00;
    out_base      = 16'h0C00;
    in2_broadcast = 1'b1;
    set_p(32'h0600_0000);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(25);
    check_op("busy_start", 10, 16'h0100, 16'h0200, 16'h0300, 1'b0, s, 99, 0,
             32'h0500_0000);

    clear_log();
    op(16'd4, 16'hFFFE, 16'h0000, 16'hFFFD, 1'b0, 32'h0700_0000, s);
    tick(15);
    check_op("wrap", 4, 16'hFFFE, 16'h0000, 16'hFFFD, 1'b0, s, 99, 0,
             32'h0700_0000);

    op(16'd20, 16'h0500, 16'h0600, 16'h0700, 1'b0, 32'h0800_0000, s);
    tick(5);
    clear_log();
    rst = 1'b0;
    #1;
    chk("midrst.rd_en", rd_en, 0);
    chk("midrst.dp_in_valid", dp_in_valid, 0);
    chk("midrst.wr_en", wr_en, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.rd_addr1", rd_addr1, 0);
    chk("midrst.wr_addr", wr_addr, 0);
    chk("midrst.cfg_mult", cfg_mult, 0);
    tick(2);
    rst = 1'b1;
    stray = 1'b1;
    tick(3);
    stray = 1'b0;
    tick(12);
    chk("midrst.wr_n", wr_c.size(), 0);
    chk("midrst.done_n", dn_c.size(), 0);
    chk("midrst.rd_n", rd_c.size(), 0);

    clear_log();
    op(16'd3, 16'h0010, 16'h0020, 16'h0030, 1'b0, 32'h0900_0000, s);
    tick(15);
    check_op("after_rst", 3, 16'h0010, 16'h0020, 16'h0030, 1'b0, s, 99, 0,
             32'h0900_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
